// File: rtl/alu_issue_queue_if.sv
// Bundle between before_dispatch, the wakeup network, the ALU0 issue queue and the ALU pipe register.
// The master side drives dispatch groups, wakeups and stall; the slave side is the queue.
interface alu_issue_queue_if #(
  parameter int PR_W      = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 32
);
  logic                   flush;
  logic                   wr_pause;
  logic [15:0]            inst_IQ_choose;
  logic [4*ROB_W-1:0]     inst_ROB_ID;
  logic [4*PR_W-1:0]      inst_src1_PR;
  logic [3:0]             inst_src1_rdy;
  logic [4*PR_W-1:0]      inst_src2_PR;
  logic [3:0]             inst_src2_rdy;
  logic [4*PR_W-1:0]      inst_dest_PR;
  logic [3:0]             inst_dest_en;
  logic [4*PAYLOAD_W-1:0] inst_payload;
  logic [1:0]             wakeup_vld;
  logic [2*PR_W-1:0]      wakeup_PR;
  logic                   issue_stall;
  logic                   IQ_pause;
  logic                   issue_vld;
  logic [ROB_W-1:0]       issue_ROB_ID;
  logic [PR_W-1:0]        issue_src1_PR;
  logic [PR_W-1:0]        issue_src2_PR;
  logic [PR_W-1:0]        issue_dest_PR;
  logic                   issue_dest_en;
  logic [PAYLOAD_W-1:0]   issue_payload;

  modport master (
    output flush, wr_pause, inst_IQ_choose, inst_ROB_ID, inst_src1_PR, inst_src1_rdy,
           inst_src2_PR, inst_src2_rdy, inst_dest_PR, inst_dest_en, inst_payload,
           wakeup_vld, wakeup_PR, issue_stall,
    input  IQ_pause, issue_vld, issue_ROB_ID, issue_src1_PR, issue_src2_PR,
           issue_dest_PR, issue_dest_en, issue_payload
  );

  modport slave (
    input  flush, wr_pause, inst_IQ_choose, inst_ROB_ID, inst_src1_PR, inst_src1_rdy,
           inst_src2_PR, inst_src2_rdy, inst_dest_PR, inst_dest_en, inst_payload,
           wakeup_vld, wakeup_PR, issue_stall,
    output IQ_pause, issue_vld, issue_ROB_ID, issue_src1_PR, issue_src2_PR,
           issue_dest_PR, issue_dest_en, issue_payload
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU0 issue queue: compacting age-ordered buffer (index 0 = oldest) that issues the oldest
// entry with both sources ready, one per cycle, into a registered issue slot.
module alu_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PR_W      = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 32,
  parameter int IQ_SEL    = 0
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [ROB_W-1:0]     robId;
    logic [PR_W-1:0]      src1Pr;
    logic                 src1Rdy;
    logic [PR_W-1:0]      src2Pr;
    logic                 src2Rdy;
    logic [PR_W-1:0]      destPr;
    logic                 destEn;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  typedef struct packed {
    logic [ROB_W-1:0]     robId;
    logic [PR_W-1:0]      src1Pr;
    logic [PR_W-1:0]      src2Pr;
    logic [PR_W-1:0]      destPr;
    logic                 destEn;
    logic [PAYLOAD_W-1:0] payload;
  } issue_t;

  entry_t        entry_q [DEPTH];
  entry_t        entry_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  issue_t        issue_q, issue_d;
  logic          issueVld_q, issueVld_d;

  logic [CW-1:0] req;
  logic          pause;
  logic          selFound;
  logic [IW-1:0] selIdx;
  logic          selfWake;
  logic [PR_W-1:0] selfTag;

  // Only the IQ_SEL bit of each slot's choose field matters to this queue.
  logic unusedChoose;
  assign unusedChoose = ^bus.inst_IQ_choose;

  function automatic logic tagHit(input logic [PR_W-1:0] tag, input logic [1:0] vld,
                                  input logic [2*PR_W-1:0] prs, input logic sEn,
                                  input logic [PR_W-1:0] sTag);
    return (vld[0] && tag == prs[PR_W-1:0]) || (vld[1] && tag == prs[2*PR_W-1:PR_W]) ||
           (sEn && tag == sTag);
  endfunction

  always_comb begin
    req = '0;
    for (int k = 0; k < 4; k++)
      if (bus.inst_IQ_choose[4*k+IQ_SEL]) req = req + CW'(1);
  end

  // Pause compares against the start-of-cycle count only, so it never loops through wr_pause.
  assign pause = req > (DEPTH_C - count_q);

  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    if (!bus.issue_stall)
      for (int i = DEPTH - 1; i >= 0; i--)
        if (CW'(i) < count_q && entry_q[i].src1Rdy && entry_q[i].src2Rdy) begin
          selFound = 1'b1;
          selIdx   = IW'(i);
        end
  end

  assign selfWake = selFound && entry_q[selIdx].destEn;
  assign selfTag  = entry_q[selIdx].destPr;

  always_comb begin
    entry_t        newEnt;
    logic [CW-1:0] wrIdx;
    newEnt     = '0;
    entry_d    = entry_q;
    issue_d    = issue_q;
    issueVld_d = issueVld_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i].src1Rdy = entry_q[i].src1Rdy | tagHit(entry_q[i].src1Pr, bus.wakeup_vld,
                                                       bus.wakeup_PR, selfWake, selfTag);
      entry_d[i].src2Rdy = entry_q[i].src2Rdy | tagHit(entry_q[i].src2Pr, bus.wakeup_vld,
                                                       bus.wakeup_PR, selfWake, selfTag);
    end
    if (selFound)
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= int'(selIdx)) entry_d[i] = entry_d[i+1];
    wrIdx = count_q - {{(CW-1){1'b0}}, selFound};
    // Pause also gates the write so the queue can never overflow, whatever wr_pause does.
    if (!bus.wr_pause && !pause && !bus.flush)
      for (int k = 0; k < 4; k++)
        if (bus.inst_IQ_choose[4*k+IQ_SEL]) begin
          newEnt.robId   = bus.inst_ROB_ID[k*ROB_W +: ROB_W];
          newEnt.src1Pr  = bus.inst_src1_PR[k*PR_W +: PR_W];
          newEnt.src2Pr  = bus.inst_src2_PR[k*PR_W +: PR_W];
          newEnt.destPr  = bus.inst_dest_PR[k*PR_W +: PR_W];
          newEnt.destEn  = bus.inst_dest_en[k];
          newEnt.payload = bus.inst_payload[k*PAYLOAD_W +: PAYLOAD_W];
          newEnt.src1Rdy = bus.inst_src1_rdy[k] | tagHit(newEnt.src1Pr, bus.wakeup_vld,
                                                         bus.wakeup_PR, selfWake, selfTag);
          newEnt.src2Rdy = bus.inst_src2_rdy[k] | tagHit(newEnt.src2Pr, bus.wakeup_vld,
                                                         bus.wakeup_PR, selfWake, selfTag);
          if (wrIdx < DEPTH_C) entry_d[wrIdx[IW-1:0]] = newEnt;
          wrIdx = wrIdx + CW'(1);
        end
    count_d = wrIdx;
    if (!bus.issue_stall) begin
      issueVld_d = selFound;
      if (selFound) begin
        issue_d.robId   = entry_q[selIdx].robId;
        issue_d.src1Pr  = entry_q[selIdx].src1Pr;
        issue_d.src2Pr  = entry_q[selIdx].src2Pr;
        issue_d.destPr  = entry_q[selIdx].destPr;
        issue_d.destEn  = entry_q[selIdx].destEn;
        issue_d.payload = entry_q[selIdx].payload;
      end
    end
    if (bus.flush) begin
      count_d    = '0;
      issueVld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q    <= '{default: '0};
      count_q    <= '0;
      issue_q    <= '0;
      issueVld_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      count_q    <= count_d;
      issue_q    <= issue_d;
      issueVld_q <= issueVld_d;
    end
  end

  assign bus.IQ_pause      = pause;
  assign bus.issue_vld     = issueVld_q;
  assign bus.issue_ROB_ID  = issue_q.robId;
  assign bus.issue_src1_PR = issue_q.src1Pr;
  assign bus.issue_src2_PR = issue_q.src2Pr;
  assign bus.issue_dest_PR = issue_q.destPr;
  assign bus.issue_dest_en = issue_q.destEn;
  assign bus.issue_payload = issue_q.payload;
endmodule
